// File: rtl/hk_fetch_sequencer.sv
// hk_fetch_sequencer: sequences H0..H7 then K0..K(NUM_K-1) reads from the H/K memory into a valid/ack stream
// Ports: CLK/RST (sync, active-high), MEM_RDY memory ready, START begin pass, ABORT end pass,
//        W_ACK consumer accept, MEM_DR read data; HK_SELECTOR/H_ADDR/K_ADDR memory address,
//        W_DATA/W_VALID/W_IS_K/W_INDEX fetched word, BUSY pass active, DONE normal-end pulse.
module hk_fetch_sequencer #(
  parameter int NUM_K    = 64,
  parameter int READ_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_RDY,
  input  logic        START,
  input  logic        ABORT,
  input  logic        W_ACK,
  input  logic [31:0] MEM_DR,
  output logic        HK_SELECTOR,
  output logic [2:0]  H_ADDR,
  output logic [5:0]  K_ADDR,
  output logic [31:0] W_DATA,
  output logic        W_VALID,
  output logic        W_IS_K,
  output logic [5:0]  W_INDEX,
  output logic        BUSY,
  output logic        DONE
);
  typedef enum logic [2:0] {S_WAIT_RDY, S_IDLE, S_WAIT, S_HOLD, S_FIN} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic sel_q, sel_d;
  logic [2:0] h_addr_q, h_addr_d;
  logic [5:0] k_addr_q, k_addr_d;
  logic [31:0] w_data_q, w_data_d;
  logic w_valid_q, w_valid_d, w_is_k_q, w_is_k_d;
  logic [5:0] w_index_q, w_index_d;
  logic busy_q, busy_d, done_q, done_d;
  logic last_cnt, h_last, k_last;
  assign last_cnt = cnt_q == 3'(READ_LAT - 1);
  assign h_last   = h_addr_q == 3'd7;
  assign k_last   = sel_q && k_addr_q == 6'(NUM_K - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_WAIT_RDY;
      cnt_q     <= '0;
      sel_q     <= 1'b0;
      h_addr_q  <= '0;
      k_addr_q  <= '0;
      w_data_q  <= '0;
      w_valid_q <= 1'b0;
      w_is_k_q  <= 1'b0;
      w_index_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      h_addr_q  <= h_addr_d;
      k_addr_q  <= k_addr_d;
      w_data_q  <= w_data_d;
      w_valid_q <= w_valid_d;
      w_is_k_q  <= w_is_k_d;
      w_index_q <= w_index_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
  // ABORT outranks both the read capture and the ACK-driven advance
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT_RDY: state_d = MEM_RDY ? S_IDLE : S_WAIT_RDY;
      S_IDLE:     state_d = START ? S_WAIT : S_IDLE;
      S_WAIT:     state_d = ABORT ? S_IDLE : last_cnt ? S_HOLD : S_WAIT;
      S_HOLD:     state_d = ABORT ? S_IDLE : !W_ACK ? S_HOLD : k_last ? S_FIN : S_WAIT;
      S_FIN:      state_d = S_IDLE;
      default:    state_d = S_WAIT_RDY;
    endcase
  end
  always_comb begin
    sel_d     = sel_q;
    h_addr_d  = h_addr_q;
    k_addr_d  = k_addr_q;
    w_data_d  = w_data_q;
    w_valid_d = w_valid_q;
    w_is_k_d  = w_is_k_q;
    w_index_d = w_index_q;
    cnt_d     = (state_q == S_WAIT && state_d == S_WAIT) ? cnt_q + 3'd1 : '0;
    busy_d    = state_d == S_WAIT || state_d == S_HOLD;
    done_d    = state_d == S_FIN;
    if (state_q == S_WAIT && state_d == S_HOLD) begin
      w_data_d  = MEM_DR;
      w_valid_d = 1'b1;
      w_is_k_d  = sel_q;
      w_index_d = sel_q ? k_addr_q : {3'b000, h_addr_q};
    end
    if (state_q == S_HOLD && state_d != S_HOLD) w_valid_d = 1'b0;
    // H_ADDR parks at 7 once the K bank is selected
    if (state_q == S_HOLD && state_d == S_WAIT) begin
      sel_d    = sel_q | h_last;
      h_addr_d = (sel_q || h_last) ? h_addr_q : h_addr_q + 3'd1;
      k_addr_d = sel_q ? k_addr_q + 6'd1 : '0;
    end
    if (state_q == S_IDLE || state_d == S_IDLE) begin
      sel_d    = 1'b0;
      h_addr_d = '0;
      k_addr_d = '0;
    end
  end
  assign HK_SELECTOR = sel_q;
  assign H_ADDR      = h_addr_q;
  assign K_ADDR      = k_addr_q;
  assign W_DATA      = w_data_q;
  assign W_VALID     = w_valid_q;
  assign W_IS_K      = w_is_k_q;
  assign W_INDEX     = w_index_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
endmodule

// File: tb/tb_hk_fetch_sequencer.sv
// tb_hk_fetch_sequencer: two configurations checked cycle-by-cycle against a word-sequence reference model
module tb_hk_fetch_sequencer;
  logic clk = 1'b0;
  logic rst, rdy, st0, ab0, ack0, st1, ab1, ack1;
  logic [31:0] dr0, dr1, wd0, wd1;
  logic sel0, wv0, wk0, bz0, dn0, sel1, wv1, wk1, bz1, dn1;
  logic [2:0] ha0, ha1;
  logic [5:0] ka0, wi0, ka1, wi1;
  int checks = 0, errors = 0;
  int a0, p1 = 0, p2 = 0;
  logic [31:0] hk [72] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19,
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  // ph: 0 memory not ready, 1 idle, 2 pass running, 3 done pulse; n = word number in the pass (H0..H7 = 0..7, then K)
  typedef struct packed { int ph; int n; int t; bit v; } mdl_t;
  mdl_t m0 = '0, m1 = '0;

  always #5 clk = ~clk;

  // memory with combinational read for READ_LAT=1, two register stages for READ_LAT=3
  always_comb begin
    a0  = sel0 ? int'(ka0) + 8 : int'(ha0);
    dr0 = hk[a0];
  end
  always @(posedge clk) begin
    p1 <= sel1 ? int'(ka1) + 8 : int'(ha1);
    p2 <= p1;
  end
  assign dr1 = hk[p2];

  hk_fetch_sequencer u0 (
    .CLK(clk), .RST(rst), .MEM_RDY(rdy), .START(st0), .ABORT(ab0), .W_ACK(ack0), .MEM_DR(dr0),
    .HK_SELECTOR(sel0), .H_ADDR(ha0), .K_ADDR(ka0), .W_DATA(wd0), .W_VALID(wv0), .W_IS_K(wk0),
    .W_INDEX(wi0), .BUSY(bz0), .DONE(dn0));
  hk_fetch_sequencer #(.NUM_K(4), .READ_LAT(3)) u1 (
    .CLK(clk), .RST(rst), .MEM_RDY(rdy), .START(st1), .ABORT(ab1), .W_ACK(ack1), .MEM_DR(dr1),
    .HK_SELECTOR(sel1), .H_ADDR(ha1), .K_ADDR(ka1), .W_DATA(wd1), .W_VALID(wv1), .W_IS_K(wk1),
    .W_INDEX(wi1), .BUSY(bz1), .DONE(dn1));

  function automatic mdl_t mstep(mdl_t m, bit r, bit y, bit s, bit a, bit k, int nk, int rl);
    mdl_t x = m;
    if (r) x = '0;
    else case (m.ph)
      0: if (y) x.ph = 1;
      1: if (s) begin x.ph = 2; x.n = 0; x.t = 0; x.v = 0; end
      2: if (a) begin x.ph = 1; x.v = 0; end
         else if (m.v) begin
           if (k) begin
             x.v = 0;
             x.t = 0;
             if (m.n == 8 + nk - 1) x.ph = 3;
             else x.n = m.n + 1;
           end
         end else begin
           x.t = m.t + 1;
           if (x.t == rl) x.v = 1;
         end
      default: x.ph = 1;
    endcase
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp_dut(input string p, input mdl_t m, input logic sel, input logic [2:0] ha,
                         input logic [5:0] ka, input logic [31:0] wd, input logic wv, input logic wk,
                         input logic [5:0] wi, input logic bz, input logic dn);
    chk({p, " BUSY"}, 32'(bz), 32'(m.ph == 2));
    chk({p, " DONE"}, 32'(dn), 32'(m.ph == 3));
    chk({p, " W_VALID"}, 32'(wv), 32'(m.v));
    if (m.v) begin
      chk({p, " W_DATA"}, wd, hk[m.n]);
      chk({p, " W_IS_K"}, 32'(wk), 32'(m.n >= 8));
      chk({p, " W_INDEX"}, 32'(wi), 32'(m.n >= 8 ? m.n - 8 : m.n));
    end
    if (m.ph == 2) begin
      chk({p, " HK_SELECTOR"}, 32'(sel), 32'(m.n >= 8));
      if (m.n >= 8) chk({p, " K_ADDR"}, 32'(ka), 32'(m.n - 8));
      else chk({p, " H_ADDR"}, 32'(ha), 32'(m.n));
    end
    if (m.ph < 2) chk({p, " idle addr"}, 32'({sel, ha, ka}), 32'd0);
  endtask

  task automatic tick();
    bit r = rst, y = rdy, s0 = st0, b0 = ab0, k0 = ack0, s1 = st1, b1 = ab1, k1 = ack1;
    @(posedge clk);
    m0 = mstep(m0, r, y, s0, b0, k0, 64, 1);
    m1 = mstep(m1, r, y, s1, b1, k1, 4, 3);
    #1;
    cmp_dut("u0", m0, sel0, ha0, ka0, wd0, wv0, wk0, wi0, bz0, dn0);
    cmp_dut("u1", m1, sel1, ha1, ka1, wd1, wv1, wk1, wi1, bz1, dn1);
  endtask

  initial begin
    int n, last, words;
    rst = 1; rdy = 0; st0 = 0; ab0 = 0; ack0 = 0; st1 = 0; ab1 = 0; ack1 = 0;
    repeat (3) tick();
    chk("reset W_DATA", wd0, 32'h0);
    chk("reset W_INDEX", 32'(wi0), 32'h0);
    chk("reset W_DATA u1", wd1, 32'h0);
    rst = 0;
    st0 = 1; tick(); st0 = 0;
    repeat (4) tick();
    chk("gated BUSY", 32'(bz0), 32'h0);
    rdy = 1; tick(); tick();
    ack0 = 1; st0 = 1; tick(); st0 = 0; n = 1;
    chk("start BUSY", 32'(bz0), 32'h1);
    tick(); n++;
    chk("first W_VALID", 32'(wv0), 32'h1);
    chk("first W_DATA", wd0, 32'h6a09e667);
    while (n < 400 && !dn0) begin
      tick(); n++;
      if (wv0 && wk0 && wi0 == 6'd0) chk("K0 data", wd0, 32'h428a2f98);
      if (wv0 && wk0 && wi0 == 6'd63) chk("K63 data", wd0, 32'hc67178f2);
    end
    chk("pass DONE cycle", n, 145);
    chk("pass DONE seen", 32'(dn0), 32'h1);
    tick();
    chk("DONE single", 32'(dn0), 32'h0);
    st0 = 1; tick(); st0 = 0; n = 0;
    while (n < 50 && !(wv0 && !wk0 && wi0 == 6'd3)) begin tick(); n++; end
    chk("H3 reached", 32'(wv0 && !wk0 && wi0 == 6'd3), 32'h1);
    ack0 = 0;
    repeat (5) begin
      tick();
      chk("bp W_DATA", wd0, 32'ha54ff53a);
      chk("bp W_VALID", 32'(wv0), 32'h1);
      chk("bp H_ADDR", 32'(ha0), 32'h3);
    end
    ack0 = 1; tick(); n = 0;
    while (n < 10 && !wv0) begin tick(); n++; end
    chk("H4 data", wd0, 32'h510e527f);
    chk("H4 index", 32'(wi0), 32'h4);
    n = 0;
    while (n < 2000 && !dn0) begin ack0 = 1'($urandom_range(0, 1)); tick(); n++; end
    chk("random pass DONE", 32'(dn0), 32'h1);
    tick();
    ack0 = 1; st0 = 1; tick(); st0 = 0; n = 0;
    while (n < 100 && !(wv0 && wk0 && wi0 == 6'd10)) begin tick(); n++; end
    chk("K10 reached", 32'(wv0 && wk0 && wi0 == 6'd10), 32'h1);
    ab0 = 1; tick(); ab0 = 0;
    chk("abort W_VALID", 32'(wv0), 32'h0);
    chk("abort BUSY", 32'(bz0), 32'h0);
    chk("abort K_ADDR", 32'(ka0), 32'h0);
    chk("abort DONE", 32'(dn0), 32'h0);
    repeat (3) tick();
    ab0 = 1; tick(); ab0 = 0;
    st0 = 1; tick(); st0 = 0; tick();
    chk("restart index", 32'({wv0, wk0, wi0}), 32'h80);
    chk("restart data", wd0, 32'h6a09e667);
    n = 0;
    while (n < 1000 && !(wv0 && wk0 && wi0 == 6'd20)) begin ack0 = 1'($urandom_range(0, 1)); tick(); n++; end
    chk("K20 reached", 32'(wv0 && wk0 && wi0 == 6'd20), 32'h1);
    rst = 1; rdy = 0; tick(); rst = 0;
    chk("rst outputs", 32'({sel0, ha0, ka0, wv0, wk0, wi0, bz0, dn0}), 32'h0);
    chk("rst W_DATA", wd0, 32'h0);
    st0 = 1; tick(); st0 = 0;
    repeat (3) tick();
    chk("rst gated BUSY", 32'(bz0), 32'h0);
    rdy = 1; tick();
    st0 = 1; tick(); st0 = 0; n = 0;
    while (n < 2000 && !dn0) begin
      if (n == 30) rdy = 0;
      ack0 = 1'($urandom_range(0, 1));
      tick(); n++;
    end
    chk("post-rst pass DONE", 32'(dn0), 32'h1);
    rdy = 1; tick();
    ack1 = 1; st1 = 1; tick(); st1 = 0; n = 1; last = -1; words = 0;
    while (n < 200 && !dn1) begin
      st1 = (n == 10 || n == 27);
      tick(); n++;
      if (wv1) begin
        words++;
        if (last >= 0) chk("u1 spacing", n - last, 4);
        else chk("u1 first valid", n, 4);
        last = n;
      end
    end
    st1 = 0;
    chk("u1 words", words, 12);
    chk("u1 DONE cycle", n, 49);
    st1 = 1; tick(); st1 = 0;
    chk("u1 start at FIN", 32'(bz1), 32'h0);
    tick();
    st1 = 1; tick(); st1 = 0; n = 0;
    while (n < 500 && !dn1) begin ack1 = 1'($urandom_range(0, 1)); tick(); n++; end
    chk("u1 random DONE", 32'(dn1), 32'h1);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
